// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM->WB pipeline boundary: default widths,
// the write-back bundle layout and a helper for the bundle width.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 4;

  // Write-back bundle carried from MEM to WB (default widths).
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] mem_data;
    logic [DEST_W_DEF-1:0] dest;
  } wb_bundle_t;

  localparam int WB_BUNDLE_W = $bits(wb_bundle_t);

  // Bundle width for arbitrary widths: two control bits plus the payload.
  function automatic int bundle_w(input int data_w, input int dest_w);
    return 2 + (2 * data_w) + dest_w;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline storage entry: a valid bit, the two write-back controls and
// the data payload {alu_result, mem_data, dest}. Writing an invalid entry
// always zeroes the controls so a stale wb_en cannot survive a bubble.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEST_W     = DEST_W_DEF,
  parameter int CLEAR_DATA = 0,
  parameter int PAY_W      = bundle_w(DATA_W, DEST_W) - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [1:0]       i_ctrl,
  input  logic [PAY_W-1:0] i_data,
  output logic             o_valid,
  output logic [1:0]       o_ctrl,
  output logic [PAY_W-1:0] o_data
);

  logic             r_valid;
  logic [1:0]       r_ctrl;
  logic [PAY_W-1:0] r_data;

  // Entry register: async clear, load valid content or a bubble, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= 2'b00;
      r_data  <= {PAY_W{1'b0}};
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_ctrl <= i_ctrl;
        r_data <= i_data;
      end else begin
        r_ctrl <= 2'b00;
        if (CLEAR_DATA != 0) begin
          r_data <= {PAY_W{1'b0}};
        end else begin
          r_data <= r_data;
        end
      end
    end else begin
      r_valid <= r_valid;
      r_ctrl  <= r_ctrl;
      r_data  <= r_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB boundary register with valid/ready handshake and a one-entry skid
// buffer. in_ready depends only on the registered skid valid bit, so there is
// no combinational path from out_ready back to the MEM stage.
module mem_wb_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEST_W     = DEST_W_DEF,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] wb_value,
  output logic              fwd_hit_en,
  output logic [DEST_W-1:0] fwd_dest
);

  localparam int PAY_W = bundle_w(DATA_W, DEST_W) - 2;

  logic             w_acc;
  logic             w_pop;
  logic             w_main_free;
  logic [1:0]       w_in_ctrl;
  logic [PAY_W-1:0] w_in_data;

  logic             w_main_valid;
  logic [1:0]       w_main_ctrl;
  logic [PAY_W-1:0] w_main_data;
  logic             w_skid_valid;
  logic [1:0]       w_skid_ctrl;
  logic [PAY_W-1:0] w_skid_data;

  logic             w_main_load;
  logic             w_main_d_valid;
  logic [1:0]       w_main_d_ctrl;
  logic [PAY_W-1:0] w_main_d_data;
  logic             w_skid_load;
  logic             w_skid_d_valid;

  assign w_in_ctrl   = {in_wb_en, in_mem_r_en};
  assign w_in_data   = {in_alu_result, in_mem_data, in_dest};
  assign in_ready    = ~w_skid_valid;
  assign w_acc       = in_valid & in_ready;
  assign w_pop       = w_main_valid & out_ready;
  assign w_main_free = ~w_main_valid | w_pop;

  // Steering: flush kills both entries; a free main slot drains the skid
  // first (preserving order) or takes the input; a stalled main diverts the
  // accepted input into the skid.
  always_comb begin
    w_main_load    = 1'b0;
    w_main_d_valid = 1'b0;
    w_main_d_ctrl  = w_in_ctrl;
    w_main_d_data  = w_in_data;
    w_skid_load    = 1'b0;
    w_skid_d_valid = 1'b0;
    if (flush) begin
      w_main_load = 1'b1;
      w_skid_load = 1'b1;
    end else if (w_main_free) begin
      w_main_load = 1'b1;
      if (w_skid_valid) begin
        w_main_d_valid = 1'b1;
        w_main_d_ctrl  = w_skid_ctrl;
        w_main_d_data  = w_skid_data;
        w_skid_load    = 1'b1;
      end else begin
        w_main_d_valid = w_acc;
      end
    end else if (w_acc) begin
      w_skid_load    = 1'b1;
      w_skid_d_valid = 1'b1;
    end else begin
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
    end
  end

  pipe_entry #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_valid (w_main_d_valid),
    .i_ctrl  (w_main_d_ctrl),
    .i_data  (w_main_d_data),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  pipe_entry #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_valid (w_skid_d_valid),
    .i_ctrl  (w_in_ctrl),
    .i_data  (w_in_data),
    .o_valid (w_skid_valid),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

  assign out_valid      = w_main_valid;
  assign out_wb_en      = w_main_ctrl[1] & w_main_valid;
  assign out_mem_r_en   = w_main_ctrl[0] & w_main_valid;
  assign out_alu_result = w_main_data[PAY_W-1 -: DATA_W];
  assign out_mem_data   = w_main_data[DEST_W +: DATA_W];
  assign out_dest       = w_main_data[DEST_W-1:0];
  assign wb_value       = out_mem_r_en ? out_mem_data : out_alu_result;
  assign fwd_hit_en     = out_valid & out_wb_en;
  assign fwd_dest       = out_dest;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: two instances (CLEAR_DATA=0 and 1) share the
// stimulus. The reference is a two-deep FIFO queue of accepted items.
module tb_mem_wb_skid_reg;

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [3:0]  dest;
  } item_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_wb_en, in_mem_r_en, out_ready;
  logic [31:0] in_alu_result, in_mem_data;
  logic [3:0]  in_dest;

  logic a_in_ready, a_out_valid, a_out_wb_en, a_out_mem_r_en, a_fwd_hit_en;
  logic [31:0] a_out_alu_result, a_out_mem_data, a_wb_value;
  logic [3:0]  a_out_dest, a_fwd_dest;
  logic b_in_ready, b_out_valid, b_out_wb_en, b_out_mem_r_en, b_fwd_hit_en;
  logic [31:0] b_out_alu_result, b_out_mem_data, b_wb_value;
  logic [3:0]  b_out_dest, b_fwd_dest;

  int n_chk = 0;
  int n_err = 0;
  item_t q[$];

  always #5 clk = ~clk;

  mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .CLEAR_DATA(0)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_dest(in_dest), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_wb_en(a_out_wb_en), .out_mem_r_en(a_out_mem_r_en),
    .out_alu_result(a_out_alu_result), .out_mem_data(a_out_mem_data),
    .out_dest(a_out_dest), .wb_value(a_wb_value), .fwd_hit_en(a_fwd_hit_en),
    .fwd_dest(a_fwd_dest));

  mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .CLEAR_DATA(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_dest(in_dest), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_wb_en(b_out_wb_en), .out_mem_r_en(b_out_mem_r_en),
    .out_alu_result(b_out_alu_result), .out_mem_data(b_out_mem_data),
    .out_dest(b_out_dest), .wb_value(b_wb_value), .fwd_hit_en(b_fwd_hit_en),
    .fwd_dest(b_fwd_dest));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the head of the reference queue.
  task automatic check_all();
    item_t h;
    logic  ev;
    logic [31:0] wbv;
    ev  = (q.size() != 0);
    h   = ev ? q[0] : '0;
    wbv = h.mr ? h.mem : h.alu;
    chk("a_in_ready", a_in_ready, q.size() < 2);
    chk("a_out_valid", a_out_valid, ev);
    chk("a_ctrl", {a_out_wb_en, a_out_mem_r_en, a_fwd_hit_en}, {ev & h.wb, ev & h.mr, ev & h.wb});
    if (ev) begin
      chk("a_data", {a_out_alu_result, a_out_mem_data}, {h.alu, h.mem});
      chk("a_dest", {a_out_dest, a_fwd_dest}, {h.dest, h.dest});
      chk("a_wb_value", a_wb_value, wbv);
    end
    chk("b_in_ready", b_in_ready, q.size() < 2);
    chk("b_out_valid", b_out_valid, ev);
    chk("b_ctrl", {b_out_wb_en, b_out_mem_r_en, b_fwd_hit_en}, {ev & h.wb, ev & h.mr, ev & h.wb});
    chk("b_data", {b_out_alu_result, b_out_mem_data}, {h.alu, h.mem});
    chk("b_dest", {b_out_dest, b_fwd_dest}, {h.dest, h.dest});
    chk("b_wb_value", b_wb_value, wbv);
  endtask

  task automatic drive(input logic v, input item_t it);
    in_valid      = v;
    in_wb_en      = it.wb;
    in_mem_r_en   = it.mr;
    in_alu_result = it.alu;
    in_mem_data   = it.mem;
    in_dest       = it.dest;
  endtask

  // One clock: reference update at the edge, then compare at the falling edge.
  task automatic cycle();
    logic rdy;
    item_t it;
    @(posedge clk);
    rdy = (q.size() < 2);
    it  = '{wb: in_wb_en, mr: in_mem_r_en, alu: in_alu_result, mem: in_mem_data, dest: in_dest};
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) q.push_back(it);
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic item_t mk(input logic wb, input logic mr, input logic [31:0] alu,
                               input logic [31:0] mem, input logic [3:0] dest);
    item_t it;
    it = '{wb: wb, mr: mr, alu: alu, mem: mem, dest: dest};
    return it;
  endfunction

  initial begin
    item_t it;
    item_t pend;
    logic  have;
    logic [31:0] stream_wb [4];
    stream_wb[0] = 32'h0000_00A0;
    stream_wb[1] = 32'h0000_0020;
    stream_wb[2] = 32'h0000_00C0;
    stream_wb[3] = 32'h0000_0040;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Streaming: four items, alternating load / ALU op.
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, mk(1'b1, k[0], 32'h10 * k, 32'hA0 + 32'h10 * (k - 1), k[3:0]));
      cycle();
      chk("stream_wb", b_wb_value, stream_wb[k-1]);
    end
    drive(1'b0, '0);
    cycle();

    // Backpressure: items 1 and 2 accepted, item 3 held by the source.
    out_ready = 1'b0;
    drive(1'b1, mk(1'b1, 1'b0, 32'h111, 32'h0, 4'd1)); cycle();
    drive(1'b1, mk(1'b1, 1'b0, 32'h222, 32'h0, 4'd2)); cycle();
    chk("bp_in_ready_low", a_in_ready, 1'b0);
    drive(1'b1, mk(1'b1, 1'b0, 32'h333, 32'h0, 4'd3)); cycle();
    out_ready = 1'b1;
    cycle();
    chk("bp_out2", a_out_dest, 4'd2);
    cycle();
    chk("bp_out3", a_out_dest, 4'd3);
    drive(1'b0, '0);
    cycle();
    chk("bp_drained", a_out_valid, 1'b0);

    // Flush with both entries full and an input presented.
    out_ready = 1'b0;
    drive(1'b1, mk(1'b1, 1'b1, 32'h5, 32'h6, 4'd5)); cycle();
    drive(1'b1, mk(1'b1, 1'b1, 32'h7, 32'h8, 4'd6)); cycle();
    out_ready = 1'b1;
    drive(1'b1, mk(1'b1, 1'b0, 32'hDEAD, 32'h0, 4'd9));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_valid", {b_out_valid, b_out_wb_en, b_fwd_hit_en, b_in_ready}, 4'b0001);
    drive(1'b0, '0);
    cycle();
    chk("flush_no_ghost", a_out_valid, 1'b0);

    // Bubble gating.
    drive(1'b1, mk(1'b1, 1'b0, 32'h55, 32'h66, 4'd7)); cycle();
    drive(1'b0, '0); cycle();
    chk("bubble_gate", {a_out_wb_en, a_fwd_hit_en, b_fwd_hit_en}, 3'b000);
    chk("bubble_clear", b_out_alu_result, 32'h0);

    // Forwarding tap.
    drive(1'b1, mk(1'b1, 1'b0, 32'h1234, 32'h9999, 4'hE)); cycle();
    chk("fwd_hit", {a_fwd_hit_en, a_fwd_dest, a_wb_value}, {1'b1, 4'hE, 32'h1234});
    drive(1'b1, mk(1'b0, 1'b0, 32'h1234, 32'h9999, 4'hE)); cycle();
    chk("fwd_nowb", a_fwd_hit_en, 1'b0);
    drive(1'b0, '0); cycle();

    // Asynchronous reset with both entries full.
    out_ready = 1'b0;
    drive(1'b1, mk(1'b1, 1'b1, 32'hA1, 32'hB1, 4'd3)); cycle();
    drive(1'b1, mk(1'b1, 1'b0, 32'hA2, 32'hB2, 4'd4)); cycle();
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("async_rst", {a_out_valid, a_in_ready, b_wb_value}, {1'b0, 1'b1, 32'h0});
    check_all();
    drive(1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Randomized traffic; the source holds an item until it is accepted.
    have = 1'b0;
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      logic acc;
      if (!have && ($urandom_range(0, 9) < 7)) begin
        pend = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  4'($urandom_range(0, 15)));
        have = 1'b1;
      end
      drive(have, pend);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      acc = have && (q.size() < 2);
      cycle();
      if (acc) have = 1'b0;
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
Parametrised MEM→WB pipeline boundary register with valid/ready handshake, a one-entry skid buffer for full-throughput backpressure, and synchronous flush. It carries the write-back controls (wb_en, mem_r_en), the ALU result, the memory read data and the destination register index from the MEM stage to the WB stage. It also provides a pre-muxed write-back value and a forwarding tap for the hazard unit.

Parameters:
DATA_W, 32, width of alu_result / mem_data / wb_value
DEST_W, 4, register-index width (4 → r0..r15)
CLEAR_DATA, 0, if 1, data fields load zero whenever a bubble or flush is written into an entry; if 0, data fields hold their previous value

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  block can accept; equals ~skid_valid (registered, no comb path from out_ready)
in_wb_en  in  1  write-back enable
in_mem_r_en  in  1  instruction is a load
in_alu_result  in  DATA_W  ALU result / address
in_mem_data  in  DATA_W  data-memory read data
in_dest  in  DEST_W  destination register
out_valid  out  1  WB stage entry valid
out_ready  in  1  WB stage consumes
out_wb_en  out  1  main.wb_en & out_valid
out_mem_r_en  out  1  main.mem_r_en & out_valid
out_alu_result  out  DATA_W  main entry ALU result
out_mem_data  out  DATA_W  main entry memory data
out_dest  out  DEST_W  main entry destination
wb_value  out  DATA_W  out_mem_r_en ? out_mem_data : out_alu_result (combinational from registers)
fwd_hit_en  out  1  out_valid & out_wb_en, for the hazard unit
fwd_dest  out  DEST_W  equals out_dest

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Each entry holds {valid, wb_en, mem_r_en, alu_result, mem_data, dest}.
- Reset (async, rst=1): both valid bits 0, all fields 0. Hence out_valid=0, out_wb_en=0, out_mem_r_en=0, all data outputs 0, wb_value=0, fwd_hit_en=0, in_ready=1.
- Handshakes: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Per-edge update when flush=0:
  - main empty or pop, skid empty: main ← input if acc, else main.valid←0 (bubble).
  - main empty or pop, skid full: main ← skid; skid.valid←0. An input cannot arrive because in_ready=0.
  - main full, no pop, acc: skid ← input; in_ready falls next cycle.
  - main full, no pop, no acc: hold.
- Latency: 1 cycle from acc to out_valid when unstalled. Throughput is 1 per cycle with out_ready held 1.
- Order is preserved: skid content always follows main.
- flush=1: at the next edge both valid bits go 0 and wb_en/mem_r_en go 0. An input accepted in that cycle is discarded. in_ready=1 on the following cycle. Flush has priority over pop, acc and stall.
- CLEAR_DATA=1: any entry written invalid loads zero data. CLEAR_DATA=0: data is don't-care but gated controls are still 0.
- rst asserted mid-transfer: contents are lost immediately, with no partial update.
- Output controls are gated by out_valid. A stale wb_en must never reach the register file.

Decomposition:
- Shared package (pipe_pkg): default widths DATA_W/DEST_W, a packed wb_bundle struct {wb_en, mem_r_en, alu_result, mem_data, dest}, and the bundle-width constant.
- One natural sub-module: pipe_entry, a single valid+bundle register with load/clear controls, instantiated twice (main, skid). Handshake and steering logic stay at top level.

Test Plan:
- Reset: assert rst mid-run with both entries full → out_valid=0, wb_value=0, in_ready=1 asynchronously, without waiting for a clock edge.
- Streaming: out_ready=1, feed 4 loads/ALU ops (dest 1..4, alu 0x10..0x40, mem 0xA0..0xD0, alternating mem_r_en) → one cycle later each appears in order; wb_value alternates 0xA0, 0x20, 0xC0, 0x40.
- Backpressure: out_ready=0 while sending 3 items → items 1 and 2 are accepted, in_ready=0 after the 2nd, item 3 is held by the source. Then out_ready=1 → outputs 1, 2, 3 in order with no loss or duplication.
- Flush: main and skid full plus in_valid=1, assert flush one cycle → next cycle out_valid=0, out_wb_en=0, fwd_hit_en=0, in_ready=1, and the flushed-cycle input never appears.
- Bubble gating: in_valid=1, in_wb_en=1, then in_valid=0 → after the instruction is popped, out_wb_en=0 and fwd_hit_en=0. With CLEAR_DATA=1, out_alu_result=0.
- Forwarding: valid entry with wb_en=1, dest=0xE, alu=0x1234 → fwd_hit_en=1, fwd_dest=0xE, wb_value=0x1234. With wb_en=0 → fwd_hit_en=0.
